// File: rtl/layer_seq_ctrl_if.sv
// layer_seq_ctrl_if: handshake bundle between top_model_ctrl, the stage engines and layer_seq_ctrl.
//   master modport: the controller/engine side (drives ln_start, layer_clr, stage_done).
//   slave modport : layer_seq_ctrl (drives stage_start, linear2_done, busy, layer_idx,
//                   cur_stage, timeout_err, err_stage).
interface layer_seq_ctrl_if #(
    parameter int NUM_LAYER = 12,
    parameter int NUM_STAGE = 7
);
    localparam int LW = $clog2(NUM_LAYER);
    logic                 ln_start;
    logic                 layer_clr;
    logic [NUM_STAGE-1:0] stage_start;
    logic [NUM_STAGE-1:0] stage_done;
    logic                 linear2_done;
    logic                 busy;
    logic [LW-1:0]        layer_idx;
    logic [2:0]           cur_stage;
    logic                 timeout_err;
    logic [2:0]           err_stage;
    modport master (
        output ln_start, layer_clr, stage_done,
        input  stage_start, linear2_done, busy, layer_idx, cur_stage, timeout_err, err_stage
    );
    modport slave (
        input  ln_start, layer_clr, stage_done,
        output stage_start, linear2_done, busy, layer_idx, cur_stage, timeout_err, err_stage
    );
endinterface

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: runs one transformer layer as 7 start/done stages (LN1..LINEAR2) per ln_start.
//   clk, rstn (async active-low) plain ports; everything else on bus (layer_seq_ctrl_if.slave):
//   in : ln_start, layer_clr, stage_done[NUM_STAGE]
//   out: stage_start[NUM_STAGE], linear2_done, busy, layer_idx, cur_stage, timeout_err, err_stage
//   Build macro STAGE_TIMEOUT_EN adds a per-stage WAIT watchdog; without it the error outputs are 0.
module layer_seq_ctrl #(
    parameter int NUM_LAYER      = 12,
    parameter int NUM_STAGE      = 7,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic            clk,
    input logic            rstn,
    layer_seq_ctrl_if.slave bus
);
    localparam int LW = $clog2(NUM_LAYER);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [NUM_STAGE-1:0] start_q, start_d;
    logic                 l2_q, l2_d;
    logic                 busy_q, busy_d;
    logic [2:0]           cur_q, cur_d;
    logic                 done_k;
    logic                 expire;
    logic                 last_k;
    assign done_k = bus.stage_done[k_q];
    assign last_k = k_q == 3'(NUM_STAGE - 1);
`ifdef STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic [2:0]    err_q, err_d;
    logic          fire;
    // cnt_q is 0 in the first WAIT cycle, so the limit is hit on the TIMEOUT_CYCLES-th WAIT cycle
    assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    // a done arriving on the limit cycle wins over the timeout
    assign fire   = state_q == WAIT && !done_k && expire;
    always_comb begin
        cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + CW'(1) : '0;
        tmo_d = tmo_q | fire;
        err_d = (fire && !tmo_q) ? k_q : err_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus.timeout_err = tmo_q;
    assign bus.err_stage   = err_q;
`else
    assign expire          = 1'b0;
    assign bus.timeout_err = 1'b0;
    assign bus.err_stage   = 3'd0;
`endif
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                // clear takes effect before a same-cycle start, so that layer runs with idx 0
                idx_d = bus.layer_clr ? '0 : idx_q;
                if (bus.ln_start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done_k) begin
                    state_d = last_k ? DONE : ISSUE;
                    k_d     = last_k ? k_q : k_q + 3'd1;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = (idx_q == LW'(NUM_LAYER - 1)) ? '0 : idx_q + LW'(1);
            end
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they come straight out of flops
        start_d = (state_d == ISSUE) ? NUM_STAGE'(1) << k_d : '0;
        l2_d    = state_d == DONE;
        busy_d  = state_d != IDLE;
        cur_d   = (state_d == IDLE) ? 3'd0 : k_d;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            start_q <= '0;
            l2_q    <= 1'b0;
            busy_q  <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            l2_q    <= l2_d;
            busy_q  <= busy_d;
            cur_q   <= cur_d;
        end
    end
    assign bus.stage_start  = start_q;
    assign bus.linear2_done = l2_q;
    assign bus.busy         = busy_q;
    assign bus.layer_idx    = idx_q;
    assign bus.cur_stage    = cur_q;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: randomized engine timing checked against a cycle timeline model of one layer.
module tb_layer_seq_ctrl;
    localparam int NL = 12;
    localparam int NS = 7;
    localparam int TO = 16;
    localparam int LW = $clog2(NL);
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    layer_seq_ctrl_if #(.NUM_LAYER(NL), .NUM_STAGE(NS)) bus();
    layer_seq_ctrl #(.NUM_LAYER(NL), .NUM_STAGE(NS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );
    int checks = 0;
    int failures = 0;
    int exp_idx = 0;
    bit exp_tmo = 1'b0;
    int exp_err = 0;
    int dly[NS];
    int ln_c = -1;
    int clr_c = -1;
    int spur_c = -1;
    logic [NS-1:0] spur_bits = '0;
    bit ghost = 1'b0;
    int obs_t;
    function automatic int stage_at(input int k);
        int s = 1 + k;
        for (int j = 0; j < k; j++) s += dly[j];
        return s;
    endfunction
    task automatic rand_dly(input int lo, input int hi);
        for (int k = 0; k < NS; k++) dly[k] = $urandom_range(hi, lo);
    endtask
    // Starts a layer in the current cycle (called at a negedge) and plays engine for every stage.
    // Stage k is issued in cycle s_k (s_0 = 1), its engine answers dly[k] cycles later, the next
    // stage is issued the cycle after that, and DONE follows the last answer by one cycle.
    // silent >= 0 names a stage whose engine never answers (timeout build only).
    task automatic run_layer(input bit clr, input int silent);
        int s[NS];
        int t, e, last, ecur, eidx;
        logic [NS-1:0] es, sd;
        bus.ln_start  = 1'b1;
        bus.layer_clr = clr;
        if (clr) exp_idx = 0;
        for (int k = 0; k < NS; k++) s[k] = stage_at(k);
        t    = s[NS-1] + dly[NS-1] + 1;
        last = silent >= 0 ? silent : NS - 1;
        e    = silent >= 0 ? s[silent] + TO + 1 : t + 1;
        eidx = exp_idx;
        obs_t = -1;
        for (int c = 1; c <= e; c++) begin
            @(negedge clk);
            es = '0;
            ecur = 0;
            for (int k = 0; k <= last; k++) begin
                if (s[k] == c) es[k] = 1'b1;
                if (s[k] <= c && c < e) ecur = k;
            end
            if (c == e && silent >= 0 && !exp_tmo) begin
                exp_tmo = 1'b1;
                exp_err = silent;
            end
            if (c == e && silent < 0) eidx = (exp_idx + 1) % NL;
            checks++;
            if (bus.stage_start !== es) begin
                failures++;
                $display("FAIL stage_start c=%0d got=%b exp=%b", c, bus.stage_start, es);
            end
            checks++;
            if (bus.linear2_done !== (silent < 0 && c == t)) begin
                failures++;
                $display("FAIL linear2_done c=%0d got=%b exp=%b", c, bus.linear2_done, silent < 0 && c == t);
            end
            checks++;
            if (bus.busy !== (c < e)) begin
                failures++;
                $display("FAIL busy c=%0d got=%b exp=%b", c, bus.busy, c < e);
            end
            checks++;
            if (bus.cur_stage !== 3'(ecur)) begin
                failures++;
                $display("FAIL cur_stage c=%0d got=%0d exp=%0d", c, bus.cur_stage, ecur);
            end
            checks++;
            if (bus.layer_idx !== LW'(eidx)) begin
                failures++;
                $display("FAIL layer_idx c=%0d got=%0d exp=%0d", c, bus.layer_idx, eidx);
            end
            checks++;
            if (bus.timeout_err !== exp_tmo || bus.err_stage !== 3'(exp_err)) begin
                failures++;
                $display("FAIL timeout c=%0d got=%b/%0d exp=%b/%0d", c, bus.timeout_err, bus.err_stage, exp_tmo, exp_err);
            end
            if (bus.linear2_done === 1'b1) obs_t = c;
            sd = '0;
            for (int k = 0; k <= last; k++) begin
                if (k != silent && s[k] + dly[k] == c) sd[k] = 1'b1;
                if (ghost && s[k] == c) sd[k] = 1'b1;
            end
            if (c == spur_c) sd |= spur_bits;
            bus.stage_done = sd;
            bus.ln_start   = (c == ln_c);
            bus.layer_clr  = (c == clr_c);
        end
        exp_idx = eidx;
        ln_c = -1;
        clr_c = -1;
        spur_c = -1;
        ghost = 1'b0;
    endtask
    task automatic test_reset();
        bus.ln_start = 1'b0;
        bus.layer_clr = 1'b0;
        bus.stage_done = '0;
        repeat (3) @(negedge clk);
        bus.ln_start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stage_start !== '0 || bus.linear2_done !== 1'b0 || bus.busy !== 1'b0 || bus.layer_idx !== '0 ||
            bus.cur_stage !== 3'd0 || bus.timeout_err !== 1'b0 || bus.err_stage !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b l2=%b busy=%b idx=%0d cur=%0d tmo=%b err=%0d exp all 0",
                     bus.stage_start, bus.linear2_done, bus.busy, bus.layer_idx, bus.cur_stage, bus.timeout_err, bus.err_stage);
        end
        bus.ln_start = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.stage_start !== '0) begin
            failures++;
            $display("FAIL reset_release got busy=%b start=%b exp 0/0", bus.busy, bus.stage_start);
        end
    endtask
    task automatic test_basic();
        for (int k = 0; k < NS; k++) dly[k] = 3;
        run_layer(1'b0, -1);
    endtask
    task automatic test_back_to_back();
        int pulses = 0;
        for (int l = 0; l < NL; l++) begin
            rand_dly(1, 4);
            run_layer(l == 0, -1);
            if (obs_t > 0) pulses++;
        end
        checks++;
        if (pulses !== NL || bus.layer_idx !== '0) begin
            failures++;
            $display("FAIL back_to_back got pulses=%0d idx=%0d exp %0d/0", pulses, bus.layer_idx, NL);
        end
    endtask
    task automatic test_ignore();
        rand_dly(1, 4);
        dly[2] = 3;
        spur_c = stage_at(2) + 1;
        spur_bits = NS'(1) << 5;
        ln_c = stage_at(4) + 1;
        clr_c = stage_at(4) + 2;
        ghost = 1'b1;
        run_layer(1'b0, -1);
        rand_dly(1, 4);
        ln_c = stage_at(NS - 1) + dly[NS-1] + 1;
        run_layer(1'b0, -1);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ln_start_in_done got busy=%b exp 0", bus.busy);
        end
    endtask
    task automatic test_zero_wait();
        for (int k = 0; k < NS; k++) dly[k] = 1;
        run_layer(1'b0, -1);
        checks++;
        if (obs_t !== 15) begin
            failures++;
            $display("FAIL zero_wait_latency got=%0d exp=15", obs_t);
        end
    endtask
    task automatic test_layer_clr();
        rand_dly(1, 3);
        run_layer(1'b1, -1);
        bus.layer_clr = 1'b1;
        @(negedge clk);
        bus.layer_clr = 1'b0;
        exp_idx = 0;
        checks++;
        if (bus.layer_idx !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL layer_clr_idle got idx=%0d busy=%b exp 0/0", bus.layer_idx, bus.busy);
        end
        rand_dly(1, 3);
        run_layer(1'b0, -1);
        rand_dly(1, 3);
        run_layer(1'b1, -1);
    endtask
    task automatic test_long_wait();
        rand_dly(1, 3);
        dly[3] = TO;
        run_layer(1'b0, -1);
    endtask
`ifdef STAGE_TIMEOUT_EN
    task automatic test_timeout();
        rand_dly(1, 3);
        run_layer(1'b0, 4);
        rand_dly(1, 3);
        run_layer(1'b0, -1);
    endtask
`endif
    task automatic test_reset_mid();
        logic [NS-1:0] sd;
        rand_dly(1, 2);
        run_layer(1'b1, -1);
        bus.ln_start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            sd = '0;
            for (int k = 0; k < NS; k++) if (3 * k + 3 == c) sd[k] = 1'b1;
            bus.stage_done = sd;
            bus.ln_start = 1'b0;
        end
        checks++;
        if (bus.cur_stage !== 3'd3 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got cur=%0d busy=%b exp 3/1", bus.cur_stage, bus.busy);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.stage_start !== '0 || bus.linear2_done !== 1'b0 || bus.busy !== 1'b0 || bus.layer_idx !== '0 ||
            bus.cur_stage !== 3'd0 || bus.timeout_err !== 1'b0 || bus.err_stage !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got start=%b busy=%b idx=%0d cur=%0d tmo=%b exp all 0",
                     bus.stage_start, bus.busy, bus.layer_idx, bus.cur_stage, bus.timeout_err);
        end
        bus.stage_done = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        exp_idx = 0;
        exp_tmo = 1'b0;
        exp_err = 0;
        rand_dly(1, 4);
        run_layer(1'b0, -1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore();
        test_zero_wait();
        test_layer_clr();
        test_long_wait();
`ifdef STAGE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
